// File: rtl/ahb_lite_pkg.sv
// Purpose: shared AHB-Lite encodings, responder FSM state, address-phase record and lane helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: none; consumers decide how to stall.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Address-phase fields held for the duration of the data phase.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
  } aphase_t;

  // Byte strobe for a transfer of the given size at byte offset addr.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  // Half-words need an even address, words a 4-byte aligned one.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr);
    return ((size == HSIZE_HALF) && addr[0]) ||
           ((size == HSIZE_WORD) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_lite_mem_slave_ram.sv
// Purpose: word-organised storage with per-byte write enable and asynchronous read.
// Latency: write commits on the rising edge; read data follows addr combinationally.
// Backpressure: none; always accepts a write.
//
// Ports:
//   clk   - write clock
//   we    - per-lane write strobe (lane 0 = bits 7:0)
//   addr  - word address, shared by read and write
//   wdata - write data, lanes selected by we
//   rdata - word at addr
module ahb_lite_mem_slave_ram
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-3:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  // Contents are deliberately not reset.
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// Purpose: AHB-Lite responder backed by a 2^ADDR_W-byte memory with OKAY/two-cycle ERROR responses.
// Latency: each data phase lasts WAIT_ST+1 cycles; with WAIT_ST=0 back-to-back beats run one per cycle.
// Backpressure: HREADYOUT low during wait states and the first ERROR cycle; new address phases only taken with HREADY high.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   HSEL, HTRANS      - select and transfer type; only NONSEQ/SEQ start a transfer
//   HADDR, HWRITE     - byte address and direction, sampled in the address phase
//   HSIZE             - byte/half/word; larger sizes get an ERROR response
//   HBURST, HPROT     - unused; every beat is handled on its own
//   HWDATA            - write data, taken in the final data-phase cycle
//   HREADY            - bus ready, qualifies the address phase
//   HRDATA            - read data, zero outside a read data cycle
//   HREADYOUT, HRESP  - slave ready and response
module ahb_lite_mem_slave
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int WAIT_ST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam bit         HAS_WAIT  = (WAIT_ST > 0);
  localparam logic [3:0] WAIT_INIT = HAS_WAIT ? 4'(WAIT_ST - 1) : 4'd0;

  state_e      state;
  logic [3:0]  wait_cnt;
  aphase_t     aph;
  logic        hreadyout_q;
  logic        hresp_q;

  logic        accept;
  logic        req_err;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  // NONSEQ and SEQ both have HTRANS[1] set; IDLE and BUSY never start a transfer.
  assign accept = HSEL & HTRANS[1] & HREADY;

  // Out-of-range is any address bit above the memory size being set.
  assign req_err = (HSIZE > HSIZE_WORD) ||
                   misaligned(HSIZE, HADDR[1:0]) ||
                   ((HADDR >> ADDR_W) != 32'd0);

  // HREADYOUT/HRESP are registered from the state being entered, so they
  // are glitch-free and already correct in the first cycle of each state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= 4'd0;
      aph         <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state       <= ST_DATA;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end

        // IDLE, DATA and ERR2 all end with HREADYOUT high, so the next
        // address phase can be taken here (pipelined back-to-back).
        default: begin
          if (accept) begin
            aph <= '{addr: HADDR, write: HWRITE, size: HSIZE};
            if (req_err) begin
              state       <= ST_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else if (HAS_WAIT) begin
              state       <= ST_WAIT;
              wait_cnt    <= WAIT_INIT;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_OKAY;
            end else begin
              state       <= ST_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= HRESP_OKAY;
            end
          end else begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // Writes commit on the edge that closes the DATA cycle, so a read whose
  // data phase follows immediately already sees the new word. Errored
  // transfers never reach DATA and therefore never write.
  assign ram_we = ((state == ST_DATA) && aph.write) ? byte_en(aph.size, aph.addr[1:0]) : 4'b0000;

  ahb_lite_mem_slave_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (aph.addr[ADDR_W-1:2]),
    .wdata (HWDATA),
    .rdata (ram_rdata)
  );

  // Read data is driven straight from the held address; the full word is
  // returned and the master picks the lanes it asked for.
  assign HRDATA    = ((state == ST_DATA) && !aph.write) ? ram_rdata : 32'd0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, aph.addr[31:ADDR_W]};

endmodule
